// File: rtl/t01_mem_arbiter.sv
// t01_mem_arbiter: three-way arbiter (fsm > dmem > imem, imem starvation guard, bus timeout) in front of the request unit
// Ports: fsm_*/dmem_* read-write requesters and imem_* fetch reads in, with per-owner *_done pulse and *_rdata out;
// read_i/write_i/data_adr/write_data out with done/read_data back from the request unit; grant_id, busy, timeout_err status.
module t01_mem_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        fsm_read,
  input  logic        fsm_write,
  input  logic [31:0] fsm_adr,
  input  logic [31:0] fsm_wdata,
  output logic        fsm_done,
  output logic [31:0] fsm_rdata,
  input  logic        dmem_read,
  input  logic        dmem_write,
  input  logic [31:0] dmem_adr,
  input  logic [31:0] dmem_wdata,
  output logic        dmem_done,
  output logic [31:0] dmem_rdata,
  input  logic        imem_read,
  input  logic [31:0] imem_adr,
  output logic        imem_done,
  output logic [31:0] imem_rdata,
  output logic        read_i,
  output logic        write_i,
  output logic [31:0] data_adr,
  output logic [31:0] write_data,
  input  logic        done,
  input  logic [31:0] read_data,
  output logic [1:0]  grant_id,
  output logic        busy,
  output logic        timeout_err
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam int WW = $clog2(TIMEOUT);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  state_t state, state_n;
  logic [WW-1:0] wcnt, wcnt_n;
  logic [SW-1:0] scnt, scnt_n;
  logic [1:0] win, grant_id_n;
  logic busy_n, read_i_n, write_i_n, fsm_done_n, dmem_done_n, imem_done_n, timeout_err_n, fin, sel_w, sel_r;
  logic [31:0] data_adr_n, write_data_n, fsm_rdata_n, dmem_rdata_n, imem_rdata_n, rd;
  always_comb begin
    win = (imem_read && scnt >= SW'(STARVE_LIMIT)) ? 2'd3 :
          (fsm_read || fsm_write) ? 2'd1 : (dmem_read || dmem_write) ? 2'd2 : imem_read ? 2'd3 : 2'd0;
    sel_w = (win == 2'd1) ? fsm_write : (win == 2'd2) ? dmem_write : 1'b0;
    sel_r = (win == 2'd1) ? fsm_read : (win == 2'd2) ? dmem_read : 1'b1;
    fin = done || wcnt == WW'(TIMEOUT - 1);
    rd = done ? read_data : '0;
    state_n = state;
    wcnt_n = wcnt;
    scnt_n = scnt;
    grant_id_n = grant_id;
    busy_n = busy;
    read_i_n = read_i;
    write_i_n = write_i;
    data_adr_n = data_adr;
    write_data_n = write_data;
    fsm_rdata_n = fsm_rdata;
    dmem_rdata_n = dmem_rdata;
    imem_rdata_n = imem_rdata;
    fsm_done_n = 1'b0;
    dmem_done_n = 1'b0;
    imem_done_n = 1'b0;
    timeout_err_n = 1'b0;
    case (state)
      IDLE: begin
        if (!imem_read) scnt_n = '0;
        if (en && win != 2'd0) begin
          state_n = ISSUE;
          grant_id_n = win;
          busy_n = 1'b1;
          write_i_n = sel_w;
          read_i_n = sel_r && !sel_w;
          data_adr_n = (win == 2'd1) ? fsm_adr : (win == 2'd2) ? dmem_adr : imem_adr;
          write_data_n = (win == 2'd1) ? fsm_wdata : (win == 2'd2) ? dmem_wdata : '0;
          scnt_n = (win == 2'd3 || !imem_read) ? '0 : scnt + SW'(scnt < SW'(STARVE_LIMIT));
        end
      end
      ISSUE: begin
        state_n = WAIT;
        wcnt_n = '0;
      end
      WAIT: begin
        if (fin) begin
          state_n = RESP;
          read_i_n = 1'b0;
          write_i_n = 1'b0;
          data_adr_n = '0;
          timeout_err_n = !done;
          fsm_done_n = grant_id == 2'd1;
          dmem_done_n = grant_id == 2'd2;
          imem_done_n = grant_id == 2'd3;
          // a completed write leaves rdata alone; reads and aborts overwrite it
          if (read_i || !done) begin
            fsm_rdata_n = (grant_id == 2'd1) ? rd : fsm_rdata;
            dmem_rdata_n = (grant_id == 2'd2) ? rd : dmem_rdata;
            imem_rdata_n = (grant_id == 2'd3) ? rd : imem_rdata;
          end
        end else wcnt_n = wcnt + 1'b1;
      end
      RESP: begin
        state_n = IDLE;
        grant_id_n = '0;
        busy_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wcnt <= '0;
      scnt <= '0;
      grant_id <= '0;
      busy <= 1'b0;
      read_i <= 1'b0;
      write_i <= 1'b0;
      data_adr <= '0;
      write_data <= '0;
      fsm_rdata <= '0;
      dmem_rdata <= '0;
      imem_rdata <= '0;
      fsm_done <= 1'b0;
      dmem_done <= 1'b0;
      imem_done <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      wcnt <= wcnt_n;
      scnt <= scnt_n;
      grant_id <= grant_id_n;
      busy <= busy_n;
      read_i <= read_i_n;
      write_i <= write_i_n;
      data_adr <= data_adr_n;
      write_data <= write_data_n;
      fsm_rdata <= fsm_rdata_n;
      dmem_rdata <= dmem_rdata_n;
      imem_rdata <= imem_rdata_n;
      fsm_done <= fsm_done_n;
      dmem_done <= dmem_done_n;
      imem_done <= imem_done_n;
      timeout_err <= timeout_err_n;
    end
  end
endmodule
